lru_repl_ctrl: RTL and testbench

LRU_REPL_CTRL -- requirements
Module: lru_repl_ctrl

---
 rtl/lru_repl_ctrl_if.sv | 36 +++
 rtl/lru_repl_ctrl.sv | 154 +++++++++++++++
 tb/tb_lru_repl_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lru_repl_ctrl_if.sv
// Request/victim/LRU-update bundle for the LRU replacement controller.
//   request side : i_req_valid, o_req_ready, i_req_hit, i_req_hit_way_8
//   selection    : i_lru_age_24 (3-bit age per way, 7 = least recent), i_valid_8
//   fill engine  : o_victim_valid, o_victim_way_8, i_fill_done
//   LRU update   : o_hit_way_8, o_lru_write_enable, o_hit_sig
//   statistics   : o_miss_cnt (saturating, CNT_W bits)
// The slave modport is the controller; the master modport is its environment.
interface lru_repl_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic             i_req_hit;
  logic [7:0]       i_req_hit_way_8;
  logic [23:0]      i_lru_age_24;
  logic [7:0]       i_valid_8;
  logic             o_victim_valid;
  logic [7:0]       o_victim_way_8;
  logic             i_fill_done;
  logic [7:0]       o_hit_way_8;
  logic             o_lru_write_enable;
  logic             o_hit_sig;
  logic [CNT_W-1:0] o_miss_cnt;

  modport slave (
    input  i_req_valid, i_req_hit, i_req_hit_way_8, i_lru_age_24, i_valid_8, i_fill_done,
    output o_req_ready, o_victim_valid, o_victim_way_8, o_hit_way_8, o_lru_write_enable,
           o_hit_sig, o_miss_cnt
  );

  modport master (
    output i_req_valid, i_req_hit, i_req_hit_way_8, i_lru_age_24, i_valid_8, i_fill_done,
    input  o_req_ready, o_victim_valid, o_victim_way_8, o_hit_way_8, o_lru_write_enable,
           o_hit_sig, o_miss_cnt
  );
endinterface

// File: rtl/lru_repl_ctrl.sv
// LRU replacement controller for an 8-way set.
// A hit with a clean one-hot way produces a one-cycle LRU update (UPDATE).
// Anything else is a miss: the victim is chosen (SELECT), handed to the fill
// engine until it reports completion (FILL), then the LRU is updated on the
// victim way (COMMIT). Misses are counted with saturation.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : lru_repl_ctrl_if slave modport (all request/fill/LRU signals)
// Every output comes straight from a flop; output flops are loaded from the
// next-state decode so they line up with the state they describe.
module lru_repl_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  lru_repl_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_UPDATE = 3'd1;
  localparam logic [2:0] ST_SELECT = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  // True when exactly one bit of w is set.
  function automatic logic is_onehot(input logic [7:0] w);
    return (w != 8'd0) && ((w & (w - 8'd1)) == 8'd0);
  endfunction

  // Victim choice: lowest-index invalid way, otherwise the oldest way.
  // The strict '>' keeps the lowest index on equal ages.
  function automatic logic [7:0] pick_victim(input logic [7:0] vld, input logic [23:0] age);
    logic       found;
    logic [2:0] inv_idx;
    logic [2:0] best_age;
    logic [2:0] best_idx;
    found    = 1'b0;
    inv_idx  = 3'd0;
    best_age = age[2:0];
    best_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!found && !vld[k]) begin
        found   = 1'b1;
        inv_idx = 3'(k);
      end else begin
        found   = found;
      end
    end
    for (int k = 1; k < 8; k++) begin
      if (age[3*k +: 3] > best_age) begin
        best_age = age[3*k +: 3];
        best_idx = 3'(k);
      end else begin
        best_idx = best_idx;
      end
    end
    return found ? (8'd1 << inv_idx) : (8'd1 << best_idx);
  endfunction

  logic [2:0]       state_r;
  logic             req_ready_r;
  logic             victim_valid_r;
  logic [7:0]       victim_r;
  logic [7:0]       hit_way_r;
  logic             hit_sig_r;
  logic [CNT_W-1:0] miss_cnt_r;

  logic [2:0]       state_nxt_s;
  logic [7:0]       victim_nxt_s;
  logic [7:0]       upd_way_s;
  logic [7:0]       hit_way_nxt_s;
  logic [CNT_W-1:0] miss_cnt_nxt_s;
  logic             accept_s;

  // Next-state, victim capture and miss-count decode.
  always_comb begin
    state_nxt_s    = state_r;
    victim_nxt_s   = victim_r;
    upd_way_s      = 8'd0;
    miss_cnt_nxt_s = miss_cnt_r;
    // req_ready_r is low on the cycle right after reset, so nothing is taken then.
    accept_s       = bus.i_req_valid & req_ready_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.i_req_hit && is_onehot(bus.i_req_hit_way_8)) begin
            state_nxt_s = ST_UPDATE;
            upd_way_s   = bus.i_req_hit_way_8;
          end else begin
            state_nxt_s = ST_SELECT;
            if (miss_cnt_r != {CNT_W{1'b1}}) begin
              miss_cnt_nxt_s = miss_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              miss_cnt_nxt_s = miss_cnt_r;
            end
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_UPDATE: state_nxt_s = ST_IDLE;
      ST_SELECT: begin
        state_nxt_s  = ST_FILL;
        victim_nxt_s = pick_victim(bus.i_valid_8, bus.i_lru_age_24);
      end
      ST_FILL: begin
        if (bus.i_fill_done) begin
          state_nxt_s = ST_COMMIT;
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase

    case (state_nxt_s)
      ST_UPDATE: hit_way_nxt_s = upd_way_s;
      ST_COMMIT: hit_way_nxt_s = victim_nxt_s;
      default:   hit_way_nxt_s = 8'd0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      req_ready_r    <= 1'b0;
      victim_valid_r <= 1'b0;
      victim_r       <= 8'd0;
      hit_way_r      <= 8'd0;
      hit_sig_r      <= 1'b0;
      miss_cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      req_ready_r    <= (state_nxt_s == ST_IDLE);
      victim_valid_r <= (state_nxt_s == ST_FILL);
      victim_r       <= victim_nxt_s;
      hit_way_r      <= hit_way_nxt_s;
      hit_sig_r      <= (state_nxt_s == ST_UPDATE) || (state_nxt_s == ST_COMMIT);
      miss_cnt_r     <= miss_cnt_nxt_s;
    end
  end

  assign bus.o_req_ready        = req_ready_r;
  assign bus.o_victim_valid     = victim_valid_r;
  assign bus.o_victim_way_8     = victim_r;
  assign bus.o_hit_way_8        = hit_way_r;
  assign bus.o_hit_sig          = hit_sig_r;
  assign bus.o_lru_write_enable = hit_sig_r;
  assign bus.o_miss_cnt         = miss_cnt_r;

endmodule

// File: tb/tb_lru_repl_ctrl.sv
// Self-checking bench for lru_repl_ctrl. Two instances share one stimulus:
// dut_a with a 16-bit miss counter and dut_b with a 4-bit one (saturation).
module tb_lru_repl_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   misses;

  lru_repl_ctrl_if #(.CNT_W(16)) bus_a ();
  lru_repl_ctrl_if #(.CNT_W(4))  bus_b ();

  lru_repl_ctrl #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  lru_repl_ctrl #(.CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  assign bus_b.i_req_valid     = bus_a.i_req_valid;
  assign bus_b.i_req_hit       = bus_a.i_req_hit;
  assign bus_b.i_req_hit_way_8 = bus_a.i_req_hit_way_8;
  assign bus_b.i_lru_age_24    = bus_a.i_lru_age_24;
  assign bus_b.i_valid_8       = bus_a.i_valid_8;
  assign bus_b.i_fill_done     = bus_a.i_fill_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected counter values follow from the number of accepted misses.
  function automatic logic [31:0] exp_cnt16();
    return (misses > 65535) ? 32'hFFFF : 32'(misses);
  endfunction
  function automatic logic [31:0] exp_cnt4();
    return (misses > 15) ? 32'hF : 32'(misses);
  endfunction

  // Reference victim: first invalid way, else the first way holding the maximum age.
  function automatic logic [7:0] ref_victim(input logic [7:0] v, input logic [23:0] ages);
    int q[$];
    int a[8];
    int mx;
    logic [7:0] r;
    r = 8'd0;
    for (int k = 0; k < 8; k++) if (v[k] == 1'b0) q.push_back(k);
    if (q.size() > 0) begin
      r[q[0]] = 1'b1;
      return r;
    end
    mx = -1;
    for (int k = 0; k < 8; k++) begin
      a[k] = int'((ages >> (3 * k)) & 24'd7);
      if (a[k] > mx) mx = a[k];
    end
    for (int k = 0; k < 8; k++) begin
      if (a[k] == mx) begin
        r[k] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // Compare all outputs of both instances against expected values.
  task automatic chk_outs(input string tag, input logic e_rdy, input logic e_vv,
                          input logic e_hs, input logic [7:0] e_hw);
    chk({tag, ".ready_a"}, 32'(bus_a.o_req_ready), 32'(e_rdy));
    chk({tag, ".vv_a"},    32'(bus_a.o_victim_valid), 32'(e_vv));
    chk({tag, ".hs_a"},    32'(bus_a.o_hit_sig), 32'(e_hs));
    chk({tag, ".we_a"},    32'(bus_a.o_lru_write_enable), 32'(e_hs));
    chk({tag, ".hw_a"},    32'(bus_a.o_hit_way_8), 32'(e_hw));
    chk({tag, ".cnt_a"},   32'(bus_a.o_miss_cnt), exp_cnt16());
    chk({tag, ".ready_b"}, 32'(bus_b.o_req_ready), 32'(e_rdy));
    chk({tag, ".hs_b"},    32'(bus_b.o_hit_sig), 32'(e_hs));
    chk({tag, ".cnt_b"},   32'(bus_b.o_miss_cnt), exp_cnt4());
  endtask

  task automatic do_hit(input logic [7:0] way);
    chk_outs("hit.pre", 1'b1, 1'b0, 1'b0, 8'd0);
    bus_a.i_req_valid = 1'b1; bus_a.i_req_hit = 1'b1; bus_a.i_req_hit_way_8 = way;
    tick();
    chk_outs("hit.update", 1'b0, 1'b0, 1'b1, way);
    // A request during UPDATE must be ignored.
    bus_a.i_req_valid = 1'($urandom_range(0, 1));
    bus_a.i_req_hit_way_8 = 8'($urandom);
    tick();
    chk_outs("hit.idle", 1'b1, 1'b0, 1'b0, 8'd0);
    bus_a.i_req_valid = 1'b0;
  endtask

  // want == 0 means the victim is taken from the reference model.
  task automatic do_miss(input logic hit, input logic [7:0] way, input logic [7:0] vld,
                         input logic [23:0] ages, input int delay, input logic [7:0] want);
    logic [7:0] vic;
    vic = (want != 8'd0) ? want : ref_victim(vld, ages);
    chk_outs("miss.pre", 1'b1, 1'b0, 1'b0, 8'd0);
    bus_a.i_req_valid = 1'b1; bus_a.i_req_hit = hit; bus_a.i_req_hit_way_8 = way;
    tick();
    misses++;
    chk_outs("miss.select", 1'b0, 1'b0, 1'b0, 8'd0);
    bus_a.i_req_valid  = 1'($urandom_range(0, 1));
    bus_a.i_valid_8    = vld;
    bus_a.i_lru_age_24 = ages;
    bus_a.i_fill_done  = 1'($urandom_range(0, 1));
    tick();
    chk_outs("miss.fill", 1'b0, 1'b1, 1'b0, 8'd0);
    chk("miss.victim_a", 32'(bus_a.o_victim_way_8), 32'(vic));
    chk("miss.victim_b", 32'(bus_b.o_victim_way_8), 32'(vic));
    for (int i = 0; i <= delay; i++) begin
      bus_a.i_valid_8    = 8'($urandom);
      bus_a.i_lru_age_24 = 24'($urandom);
      bus_a.i_req_valid  = 1'($urandom_range(0, 1));
      bus_a.i_fill_done  = (i == delay);
      tick();
      if (i < delay) begin
        chk_outs("miss.wait", 1'b0, 1'b1, 1'b0, 8'd0);
        chk("miss.hold", 32'(bus_a.o_victim_way_8), 32'(vic));
      end else begin
        chk_outs("miss.commit", 1'b0, 1'b0, 1'b1, vic);
      end
    end
    bus_a.i_req_valid = 1'b0;
    bus_a.i_fill_done = 1'($urandom_range(0, 1));
    tick();
    chk_outs("miss.idle", 1'b1, 1'b0, 1'b0, 8'd0);
    bus_a.i_fill_done = 1'b0;
  endtask

  initial begin
    logic [7:0]  w;
    logic [23:0] ages;
    int          kind;
    n_cmp = 0; n_err = 0; misses = 0;
    bus_a.i_req_valid = 1'b0; bus_a.i_req_hit = 1'b0; bus_a.i_req_hit_way_8 = 8'd0;
    bus_a.i_lru_age_24 = 24'd0; bus_a.i_valid_8 = 8'hFF; bus_a.i_fill_done = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    chk("reset.vw", 32'(bus_a.o_victim_way_8), 32'd0);
    tick(); tick();
    rst = 1'b1;
    bus_a.i_req_valid = 1'b1;
    #1;
    chk_outs("reset.release", 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    // Request was held high across the release edge; it must not have been taken.
    chk_outs("ready.rise", 1'b1, 1'b0, 1'b0, 8'd0);
    bus_a.i_req_valid = 1'b0;

    do_hit(8'b00100000);
    do_miss(1'b0, 8'd0, 8'b11110111, 24'($urandom), 3, 8'b00001000);
    do_miss(1'b0, 8'd0, 8'hFF, {3'd7, 3'd5, 3'd4, 3'd3, 3'd7, 3'd2, 3'd1, 3'd0}, 0, 8'b00001000);
    do_miss(1'b1, 8'b00000101, 8'hFF, 24'($urandom), 1, 8'd0);
    do_miss(1'b1, 8'b00000000, 8'b01111111, 24'($urandom), 2, 8'b10000000);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      ages = 24'($urandom);
      w = 8'($urandom);
      if (kind == 0) begin
        w = 8'd1 << $urandom_range(0, 7);
        do_hit(w);
      end else begin
        if (kind == 2 && $urandom_range(0, 1) == 0) w = 8'd0;
        if (kind == 2 && w != 8'd0 && (w & (w - 8'd1)) == 8'd0) w = w | 8'b10000001;
        do_miss(kind == 2, w, ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom), ages,
                $urandom_range(0, 4), 8'd0);
      end
    end

    // Abort in the middle of a fill.
    bus_a.i_req_valid = 1'b1; bus_a.i_req_hit = 1'b0;
    tick();
    misses++;
    bus_a.i_req_valid = 1'b0; bus_a.i_valid_8 = 8'hFE;
    tick();
    chk("abort.vv", 32'(bus_a.o_victim_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    misses = 0;
    chk_outs("abort.reset", 1'b0, 1'b0, 1'b0, 8'd0);
    chk("abort.vw", 32'(bus_a.o_victim_way_8), 32'd0);
    bus_a.i_fill_done = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk_outs("abort.ready", 1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs("abort.quiet", 1'b1, 1'b0, 1'b0, 8'd0);
    end
    bus_a.i_fill_done = 1'b0;

    // Twenty misses: 4-bit counter pins at 4'hF, 16-bit one reaches 20.
    for (int t = 0; t < 20; t++) begin
      do_miss(1'b0, 8'd0, 8'($urandom), 24'($urandom), $urandom_range(0, 1), 8'd0);
    end
    chk("sat.cnt_b", 32'(bus_b.o_miss_cnt), 32'hF);
    chk("sat.cnt_a", 32'(bus_a.o_miss_cnt), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
